// File: rtl/ant_pheromone_table_if.sv
// Lookup/update/evaporation-status bundle for ant_pheromone_table.
// The slave modport is the table side; the master modport is the router side.
interface ant_pheromone_table_if #(
   parameter int unsigned NODES = 16,
   parameter int unsigned PORTS = 5
);
   localparam int unsigned DEST_W = (NODES > 1) ? $clog2(NODES) : 1;
   localparam int unsigned PORT_W = (PORTS > 1) ? $clog2(PORTS) : 1;

   logic              i_lookup_valid;
   logic              o_lookup_ready;
   logic [DEST_W-1:0] i_lookup_dest;
   logic [PORT_W-1:0] i_lookup_parent;
   logic              o_result_valid;
   logic [PORTS-1:0]  o_next_output;
   logic              i_update_valid;
   logic              o_update_ready;
   logic [DEST_W-1:0] i_update_dest;
   logic [PORT_W-1:0] i_update_parent;
   logic              o_evap_busy;

   modport slave (
      input  i_lookup_valid, i_lookup_dest, i_lookup_parent,
      input  i_update_valid, i_update_dest, i_update_parent,
      output o_lookup_ready, o_result_valid, o_next_output,
      output o_update_ready, o_evap_busy
   );

   modport master (
      output i_lookup_valid, i_lookup_dest, i_lookup_parent,
      output i_update_valid, i_update_dest, i_update_parent,
      input  o_lookup_ready, o_result_valid, o_next_output,
      input  o_update_ready, o_evap_busy
   );
endinterface

// File: rtl/ant_pheromone_table.sv
// Per-router pheromone table: saturating counters per (destination, port), argmax lookup, reinforcement updates.
// Optional periodic evaporation sweep is built when ANT_PH_EVAP_EN is defined.
module ant_pheromone_table #(
   parameter int unsigned NODES       = 16,
   parameter int unsigned PORTS       = 5,
   parameter int unsigned PH_W        = 8,
   parameter int unsigned PH_INIT     = 128,
   parameter int unsigned PH_INC      = 4,
   parameter int unsigned PH_DEC      = 1,
   parameter int unsigned EVAP_PERIOD = 1024
) (
   input logic                  clk,
   input logic                  reset_n,
   ant_pheromone_table_if.slave bus
);
   localparam int unsigned DEST_W = (NODES > 1) ? $clog2(NODES) : 1;
   localparam int unsigned PORT_W = (PORTS > 1) ? $clog2(PORTS) : 1;
   localparam int unsigned COLS   = PORTS - 1;

   localparam logic [PH_W:0]   PH_MAX_X = (PH_W+1)'((1 << PH_W) - 1);
   localparam logic [PH_W:0]   PH_INC_X = (PH_W+1)'(PH_INC);
   localparam logic [PH_W:0]   PH_DEC_X = (PH_W+1)'(PH_DEC);
   localparam logic [PH_W-1:0] PH_INIT_V = PH_W'(PH_INIT);

   // column c holds the counter for port c+1
   logic [PH_W-1:0] r_table [NODES][COLS];

   logic              r_result_valid;
   logic [PORTS-1:0]  r_next_output;

   logic              w_upd_hit;
   logic              w_lookup_fire;
   logic              w_look_in_range;
   logic [PH_W-1:0]   w_upd_cur  [COLS];
   logic [PH_W-1:0]   w_upd_nxt  [COLS];
   logic [PH_W-1:0]   w_look_row [COLS];
   logic [PORTS-1:0]  w_onehot;
   logic              w_sweep_act;
   logic [DEST_W-1:0] w_sweep_row;

   assign bus.o_update_ready = 1'b1;
   assign bus.o_lookup_ready = ~bus.i_update_valid;
   assign bus.o_result_valid = r_result_valid;
   assign bus.o_next_output  = r_next_output;

   assign w_lookup_fire   = bus.i_lookup_valid & ~bus.i_update_valid;
   assign w_look_in_range = 32'(bus.i_lookup_dest) < NODES;
   assign w_upd_hit       = bus.i_update_valid
                          && (32'(bus.i_update_dest) < NODES)
                          && (bus.i_update_parent != '0)
                          && (32'(bus.i_update_parent) < PORTS);

   // row muxes for the update and lookup paths
   always_comb begin
      for (int c = 0; c < COLS; c++) begin
         w_upd_cur[c]  = '0;
         w_look_row[c] = '0;
      end
      for (int r = 0; r < NODES; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (DEST_W'(r) == bus.i_update_dest) w_upd_cur[c]  = r_table[r][c];
            if (DEST_W'(r) == bus.i_lookup_dest) w_look_row[c] = r_table[r][c];
         end
      end
   end

   // reinforce the parent column, decay the rest; one extra bit so nothing wraps
   always_comb begin : p_upd_math
      logic [PH_W:0] v_cur;
      logic [PH_W:0] v_sum;
      v_cur = '0;
      v_sum = '0;
      for (int c = 0; c < COLS; c++) begin
         v_cur = {1'b0, w_upd_cur[c]};
         v_sum = v_cur + PH_INC_X;
         if (PORT_W'(c + 1) == bus.i_update_parent)
            w_upd_nxt[c] = (v_sum > PH_MAX_X) ? PH_W'(PH_MAX_X) : PH_W'(v_sum);
         else
            w_upd_nxt[c] = (v_cur < PH_DEC_X) ? '0 : PH_W'(v_cur - PH_DEC_X);
      end
   end

   // argmax over non-parent ports, strict '>' keeps the lowest index on ties
   always_comb begin : p_argmax
      logic              v_found;
      logic [PH_W-1:0]   v_best_val;
      logic [PORT_W-1:0] v_best_idx;
      v_found    = 1'b0;
      v_best_val = '0;
      v_best_idx = '0;
      w_onehot   = '0;
      for (int k = 1; k < PORTS; k++) begin
         if (PORT_W'(k) != bus.i_lookup_parent) begin
            if (!v_found || (w_look_row[k-1] > v_best_val)) begin
               v_found    = 1'b1;
               v_best_val = w_look_row[k-1];
               v_best_idx = PORT_W'(k);
            end
         end
      end
      for (int k = 0; k < PORTS; k++)
         w_onehot[k] = w_look_in_range && (PORT_W'(k) == v_best_idx);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_result_valid <= 1'b0;
         r_next_output  <= '0;
      end else begin
         r_result_valid <= w_lookup_fire;
         if (w_lookup_fire) r_next_output <= w_onehot;
      end
   end

`ifdef ANT_PH_EVAP_EN
   localparam int unsigned CNT_W = (EVAP_PERIOD > 1) ? $clog2(EVAP_PERIOD) : 1;

   typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_period_cnt;
   logic [DEST_W-1:0] r_sweep_row;
   logic              r_evap_busy;

   // free-running period counter; expiry while sweeping is dropped
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_period_cnt <= '0;
         r_sweep_row  <= '0;
         r_evap_busy  <= 1'b0;
      end else begin
         r_period_cnt <= (r_period_cnt == CNT_W'(EVAP_PERIOD - 1)) ? '0
                                                                   : r_period_cnt + CNT_W'(1);
         case (r_state)
            ST_IDLE: begin
               if (r_period_cnt == CNT_W'(EVAP_PERIOD - 1)) begin
                  r_state     <= ST_SWEEP;
                  r_sweep_row <= '0;
                  r_evap_busy <= 1'b1;
               end
            end
            ST_SWEEP: begin
               if (r_sweep_row == DEST_W'(NODES - 1)) begin
                  r_state     <= ST_IDLE;
                  r_evap_busy <= 1'b0;
               end else begin
                  r_sweep_row <= r_sweep_row + DEST_W'(1);
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_evap_busy <= 1'b0;
            end
         endcase
      end
   end

   assign w_sweep_act     = (r_state == ST_SWEEP);
   assign w_sweep_row     = r_sweep_row;
   assign bus.o_evap_busy = r_evap_busy;
`else
   // EVAP_PERIOD only matters when the sweep is built
   assign w_sweep_act     = 1'b0 & (EVAP_PERIOD != 0);
   assign w_sweep_row     = '0;
   assign bus.o_evap_busy = 1'b0;
`endif

   // table write: an update to a row overrides that row's evaporation
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < NODES; r++)
            for (int c = 0; c < COLS; c++)
               r_table[r][c] <= PH_INIT_V;
      end else begin
         for (int r = 0; r < NODES; r++) begin
            if (w_upd_hit && (DEST_W'(r) == bus.i_update_dest)) begin
               for (int c = 0; c < COLS; c++) r_table[r][c] <= w_upd_nxt[c];
            end else if (w_sweep_act && (DEST_W'(r) == w_sweep_row)) begin
               for (int c = 0; c < COLS; c++)
                  r_table[r][c] <= (r_table[r][c] == '0) ? '0 : r_table[r][c] - PH_W'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_ant_pheromone_table.sv
// Randomized + directed bench for ant_pheromone_table against a per-edge reference model.
// Build with ANT_PH_EVAP_EN defined to also exercise the evaporation sweep.
module tb_ant_pheromone_table;
   localparam int NODES       = 16;
   localparam int PORTS       = 5;
   localparam int PH_W        = 4;
   localparam int PH_INIT     = 8;
   localparam int PH_INC      = 1;
   localparam int PH_DEC      = 1;
   localparam int EVAP_PERIOD = 32;
   localparam int PH_MAX      = (1 << PH_W) - 1;
   localparam int DEST_W      = 4;
   localparam int PORT_W      = 3;
   localparam int NODES2      = 12;
`ifdef ANT_PH_EVAP_EN
   localparam bit EVAP = 1'b1;
`else
   localparam bit EVAP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   ant_pheromone_table_if #(.NODES(NODES),  .PORTS(PORTS)) bus  ();
   ant_pheromone_table_if #(.NODES(NODES2), .PORTS(PORTS)) bus2 ();

   ant_pheromone_table #(
      .NODES(NODES), .PORTS(PORTS), .PH_W(PH_W), .PH_INIT(PH_INIT),
      .PH_INC(PH_INC), .PH_DEC(PH_DEC), .EVAP_PERIOD(EVAP_PERIOD)
   ) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   ant_pheromone_table #(
      .NODES(NODES2), .PORTS(PORTS), .PH_W(PH_W), .PH_INIT(PH_INIT),
      .PH_INC(PH_INC), .PH_DEC(PH_DEC), .EVAP_PERIOD(EVAP_PERIOD)
   ) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

   int checks   = 0;
   int failures = 0;

   // reference: m_tab[dest][port], port 0 unused; m_e = edges since reset release
   int               m_tab [NODES][PORTS];
   int               m_e;
   logic [PORTS-1:0] m_no;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int d = 0; d < NODES; d++)
         for (int p = 0; p < PORTS; p++) m_tab[d][p] = PH_INIT;
      m_e  = 0;
      m_no = '0;
   endtask

   function automatic logic [PORTS-1:0] m_lookup(input int d, input int parent);
      int best = -1;
      int bv   = -1;
      if (d >= NODES) return '0;
      for (int p = 1; p < PORTS; p++)
         if (p != parent && m_tab[d][p] > bv) begin
            bv   = m_tab[d][p];
            best = p;
         end
      return PORTS'(1) << best;
   endfunction

   task automatic m_edge(input bit uv, input int d, input int parent);
      bit hit = uv && d < NODES && parent >= 1 && parent < PORTS;
      int row = m_e % EVAP_PERIOD;
      if (hit)
         for (int p = 1; p < PORTS; p++)
            m_tab[d][p] = (p == parent) ? ((m_tab[d][p] + PH_INC > PH_MAX) ? PH_MAX : m_tab[d][p] + PH_INC)
                                        : ((m_tab[d][p] < PH_DEC) ? 0 : m_tab[d][p] - PH_DEC);
      if (EVAP && m_e >= EVAP_PERIOD && row < NODES && !(hit && d == row))
         for (int p = 1; p < PORTS; p++)
            if (m_tab[row][p] > 0) m_tab[row][p]--;
      m_e++;
   endtask

   function automatic bit m_busy();
      return EVAP && m_e >= EVAP_PERIOD && (m_e % EVAP_PERIOD) < NODES;
   endfunction

   // one clock: drive, check ready, advance model at the edge, check registered outputs
   task automatic cycle(input bit lv, input int ld, input int lp, input bit uv, input int ud, input int up);
      logic [DEST_W-1:0] dl = DEST_W'(ld);
      logic [PORT_W-1:0] pl = PORT_W'(lp);
      logic [DEST_W-1:0] du = DEST_W'(ud);
      logic [PORT_W-1:0] pu = PORT_W'(up);
      bit exp_rv;
      bus.i_lookup_valid  = lv;
      bus.i_lookup_dest   = dl;
      bus.i_lookup_parent = pl;
      bus.i_update_valid  = uv;
      bus.i_update_dest   = du;
      bus.i_update_parent = pu;
      #1;
      chk("lookup_ready", 32'(bus.o_lookup_ready), 32'(!uv));
      chk("update_ready", 32'(bus.o_update_ready), 32'd1);
      exp_rv = lv && !uv;
      if (exp_rv) m_no = m_lookup(int'(dl), int'(pl));
      @(posedge clk);
      m_edge(uv, int'(du), int'(pu));
      #1;
      chk("result_valid", 32'(bus.o_result_valid), 32'(exp_rv));
      chk("next_output", 32'(bus.o_next_output), 32'(m_no));
      chk("evap_busy", 32'(bus.o_evap_busy), 32'(m_busy()));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0, 0, 0);
   endtask

   task automatic check_table(input string tag);
      for (int d = 0; d < NODES; d++)
         for (int p = 1; p < PORTS; p++)
            chk($sformatf("%s_tab[%0d][%0d]", tag, d, p), 32'(dut.r_table[d][p-1]), 32'(m_tab[d][p]));
   endtask

   task automatic drive2(input bit lv, input int ld, input int lp, input bit uv, input int ud, input int up);
      bus2.i_lookup_valid  = lv;
      bus2.i_lookup_dest   = DEST_W'(ld);
      bus2.i_lookup_parent = PORT_W'(lp);
      bus2.i_update_valid  = uv;
      bus2.i_update_dest   = DEST_W'(ud);
      bus2.i_update_parent = PORT_W'(up);
   endtask

   initial begin
      reset_n = 1'b0;
      bus.i_lookup_valid = 1'b0;  bus.i_lookup_dest = '0;  bus.i_lookup_parent = '0;
      bus.i_update_valid = 1'b0;  bus.i_update_dest = '0;  bus.i_update_parent = '0;
      drive2(1'b0, 0, 0, 1'b0, 0, 0);
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_result_valid", 32'(bus.o_result_valid), 32'd0);
      chk("rst_next_output", 32'(bus.o_next_output), 32'd0);
      chk("rst_evap_busy", 32'(bus.o_evap_busy), 32'd0);
      check_table("rst");
      @(negedge clk) reset_n = 1'b1;

      // all-equal row: tie resolves to port 1
      cycle(1'b1, 3, 0, 1'b0, 0, 0);
      chk("tie_port1", 32'(bus.o_next_output), 32'h02);
      // reinforce port 2 of row 3
      for (int i = 0; i < 3; i++) cycle(1'b0, 0, 0, 1'b1, 3, 2);
      cycle(1'b1, 3, 0, 1'b0, 0, 0);
      cycle(1'b1, 3, 2, 1'b0, 0, 0);
      // saturate port 4 of row 5, floor the others
      for (int i = 0; i < 10; i++) cycle(1'b0, 0, 0, 1'b1, 5, 4);
      check_table("sat");
`ifndef ANT_PH_EVAP_EN
      chk("row3_p1", 32'(dut.r_table[3][0]), 32'd5);
      chk("row3_p2", 32'(dut.r_table[3][1]), 32'd11);
      chk("row5_p4", 32'(dut.r_table[5][3]), 32'd15);
      chk("row5_p1", 32'(dut.r_table[5][0]), 32'd0);
`endif
      cycle(1'b1, 5, 4, 1'b0, 0, 0);
      cycle(1'b1, 5, 0, 1'b0, 0, 0);
      // update has priority; lookup retried next cycle sees the new row
      cycle(1'b1, 5, 4, 1'b1, 5, 1);
      cycle(1'b1, 5, 4, 1'b0, 0, 0);
      // illegal parents leave the table alone
      cycle(1'b0, 0, 0, 1'b1, 5, 0);
      cycle(1'b0, 0, 0, 1'b1, 3, 7);
      cycle(1'b0, 0, 0, 1'b1, 6, 5);
      check_table("nochg");
      // parent beyond PORTS excludes nothing; then output holds while idle
      cycle(1'b1, 3, 6, 1'b0, 0, 0);
      idle(3);

      for (int i = 0; i < 3000; i++) begin
         int ld = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NODES - 1) : $urandom_range(0, 3);
         int ud = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NODES - 1) : $urandom_range(0, 3);
         cycle($urandom_range(0, 99) < 60, ld, $urandom_range(0, 7),
               $urandom_range(0, 99) < 40, ud, $urandom_range(0, 7));
         if (i % 750 == 749) check_table("rand");
      end

      // reset mid-operation with a result pending
      cycle(1'b1, 1, 0, 1'b0, 0, 0);
      bus.i_lookup_valid = 1'b0;
      bus.i_update_valid = 1'b0;
      reset_n = 1'b0;
      m_reset();
      #1;
      chk("mid_rst_valid", 32'(bus.o_result_valid), 32'd0);
      chk("mid_rst_next", 32'(bus.o_next_output), 32'd0);
      chk("mid_rst_busy", 32'(bus.o_evap_busy), 32'd0);
      check_table("mid_rst");
      @(negedge clk) reset_n = 1'b1;

      // out-of-range destinations on a 12-row table
      drive2(1'b1, 13, 0, 1'b0, 0, 0);
      idle(1);
      chk("oor_valid", 32'(bus2.o_result_valid), 32'd1);
      chk("oor_next", 32'(bus2.o_next_output), 32'd0);
      drive2(1'b0, 0, 0, 1'b1, 13, 1);
      idle(1);
      chk("oor_upd_ready", 32'(bus2.o_lookup_ready), 32'd0);
      chk("oor_upd_valid", 32'(bus2.o_result_valid), 32'd0);
      drive2(1'b1, 0, 0, 1'b0, 0, 0);
      idle(1);
      chk("n2_tie_next", 32'(bus2.o_next_output), 32'h02);
      drive2(1'b1, 14, 2, 1'b0, 0, 0);
      idle(1);
      chk("oor2_valid", 32'(bus2.o_result_valid), 32'd1);
      chk("oor2_next", 32'(bus2.o_next_output), 32'd0);
      drive2(1'b0, 0, 0, 1'b0, 0, 0);
      idle(1);
      chk("n2_idle_valid", 32'(bus2.o_result_valid), 32'd0);
      chk("n2_hold_next", 32'(bus2.o_next_output), 32'd0);

`ifdef ANT_PH_EVAP_EN
      // fresh table, update row 0 on the very edge that sweeps row 0
      bus.i_lookup_valid = 1'b0;
      bus.i_update_valid = 1'b0;
      reset_n = 1'b0;
      m_reset();
      #1;
      @(negedge clk) reset_n = 1'b1;
      while (m_e != EVAP_PERIOD) idle(1);
      cycle(1'b0, 0, 0, 1'b1, 0, 1);
      idle(NODES + 2);
      check_table("evap");
      chk("evap_row0_p1", 32'(dut.r_table[0][0]), 32'd9);
      chk("evap_row0_p2", 32'(dut.r_table[0][1]), 32'd7);
      chk("evap_row7_p3", 32'(dut.r_table[7][2]), 32'd7);
      chk("evap_row15_p4", 32'(dut.r_table[15][3]), 32'd7);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
